// File: rtl/cnt_pkg.sv
// Shared definitions for the parametrised up/down counter: terminal-count
// mode encodings and the one-shot sequencing states.
package cnt_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RELOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } os_state_t;

endpackage

// File: rtl/cnt_prescaler.sv
// Modulo-PRESC enable divider. The step strobe is high on the enabled cycle
// that completes a prescaler period.
module cnt_prescaler #(
  parameter int PRESC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESC - 1);

  logic [PW-1:0] cnt;

  assign step = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// General counter/timer primitive: width/modulus generics, run-time direction,
// four terminal-count modes, synchronous load, prescaler and tc pulse.
//
// state   | meaning
// ST_IDLE | one-shot not armed; steps ignored, prescaler held at 0
// ST_RUN  | one-shot counting from the reload value toward the terminal value
// ST_DONE | one-shot expired; count held, steps ignored until next start
module param_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int PRESC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  os_state_t        state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] term_val;
  logic             oneshot;
  logic             start_ok;
  logic             presc_step;
  logic             step_ok;
  logic             presc_clr;

  assign oneshot      = (mode == MODE_ONESHOT);
  assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
  assign term_val     = up_dn ? MAX_C : '0;
  assign start_ok     = start && oneshot && !load;
  assign step_ok      = presc_step && (!oneshot || state == ST_RUN);
  // The prescaler restarts on load/start and idles while the one-shot is not running.
  assign presc_clr    = load || start_ok || (oneshot && state != ST_RUN);

  cnt_prescaler #(.PRESC(PRESC)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (presc_clr),
    .step  (presc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      reload_q <= '0;
      tc       <= 1'b0;
      busy     <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      tc <= 1'b0;
      if (!oneshot) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end
      if (load) begin
        count_q  <= load_clamped;
        reload_q <= load_clamped;
      end else if (start_ok) begin
        count_q <= reload_q;
        state   <= ST_RUN;
        busy    <= 1'b1;
      end else if (step_ok) begin
        if (count_q == term_val) begin
          tc <= 1'b1;
          case (mode)
            MODE_WRAP:    count_q <= up_dn ? '0 : MAX_C;
            MODE_RELOAD:  count_q <= reload_q;
            MODE_ONESHOT: begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end
            default:      count_q <= count_q;
          endcase
        end else begin
          count_q <= up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
      end
    end
  end

  assign count   = count_q;
  assign count_n = ~count_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: three parameterisations share the
// stimulus; expectations are queued per cycle and checked after each edge.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up_dn, load, start;
  logic [1:0] mode;
  logic [3:0] load_val;

  logic [3:0] cnt_a, cntn_a, cnt_b, cntn_b, cnt_c, cntn_c;
  logic       tc_a, busy_a, tc_b, busy_b, tc_c, busy_c;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         dut;
    logic [3:0] cnt;
    logic       tc;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // a: defaults (MAX 15, PRESC 1); b: MAX_VAL 9; c: PRESC 3
  param_updown_counter #(.WIDTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .start(start), .count(cnt_a), .count_n(cntn_a),
    .tc(tc_a), .busy(busy_a));

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .start(start), .count(cnt_b), .count_n(cntn_b),
    .tc(tc_b), .busy(busy_b));

  param_updown_counter #(.WIDTH(4), .PRESC(3)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .mode(mode), .load(load),
    .load_val(load_val), .start(start), .count(cnt_c), .count_n(cntn_c),
    .tc(tc_c), .busy(busy_c));

  task automatic expect_out(input int dut, input logic [3:0] c, input logic t,
                            input logic b, input string tag);
    exp_t e;
    e.dut = dut; e.cnt = c; e.tc = t; e.busy = b; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [3:0] oc, ocn;
    logic       ot, ob;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin oc = cnt_a; ocn = cntn_a; ot = tc_a; ob = busy_a; end
        1:       begin oc = cnt_b; ocn = cntn_b; ot = tc_b; ob = busy_b; end
        default: begin oc = cnt_c; ocn = cntn_c; ot = tc_c; ob = busy_c; end
      endcase
      checks++;
      assert (oc === e.cnt) else begin
        failures++;
        $error("FAIL %s count got=%0d want=%0d", e.tag, oc, e.cnt);
      end
      checks++;
      assert (ocn === ~e.cnt) else begin
        failures++;
        $error("FAIL %s count_n got=%0d want=%0d", e.tag, ocn, ~e.cnt);
      end
      checks++;
      assert (ot === e.tc) else begin
        failures++;
        $error("FAIL %s tc got=%0b want=%0b", e.tag, ot, e.tc);
      end
      checks++;
      assert (ob === e.busy) else begin
        failures++;
        $error("FAIL %s busy got=%0b want=%0b", e.tag, ob, e.busy);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b0; load = 1'b0; start = 1'b0;
    mode = 2'b00; load_val = 4'd0;
    #2;
    for (int d = 0; d < 3; d++) expect_out(d, 4'd0, 1'b0, 1'b0, "reset");
    drain();
    #10 rst_n = 1'b1;

    // 1: WRAP down from reset
    en = 1'b1; up_dn = 1'b0; mode = 2'b00;
    expect_out(0, 4'd15, 1'b1, 1'b0, "wrap_dn_tc"); tick();
    for (int v = 14; v >= 0; v--) begin
      expect_out(0, 4'(v), 1'b0, 1'b0, "wrap_dn"); tick();
    end
    expect_out(0, 4'd15, 1'b1, 1'b0, "wrap_dn_tc2"); tick();

    // 2: SAT up from 13, then one step down
    mode = 2'b01; up_dn = 1'b1; load = 1'b1; load_val = 4'd13;
    expect_out(0, 4'd13, 1'b0, 1'b0, "sat_load"); tick();
    load = 1'b0;
    expect_out(0, 4'd14, 1'b0, 1'b0, "sat_14"); tick();
    expect_out(0, 4'd15, 1'b0, 1'b0, "sat_15"); tick();
    expect_out(0, 4'd15, 1'b1, 1'b0, "sat_hold1"); tick();
    expect_out(0, 4'd15, 1'b1, 1'b0, "sat_hold2"); tick();
    up_dn = 1'b0;
    expect_out(0, 4'd14, 1'b0, 1'b0, "sat_down"); tick();

    // 3: ONESHOT down from 3
    mode = 2'b10; load = 1'b1; load_val = 4'd3;
    expect_out(0, 4'd3, 1'b0, 1'b0, "os_load"); tick();
    load = 1'b0; start = 1'b1;
    expect_out(0, 4'd3, 1'b0, 1'b1, "os_start"); tick();
    start = 1'b0;
    for (int v = 2; v >= 0; v--) begin
      expect_out(0, 4'(v), 1'b0, 1'b1, "os_run"); tick();
    end
    expect_out(0, 4'd0, 1'b1, 1'b0, "os_tc"); tick();
    for (int i = 0; i < 5; i++) begin
      expect_out(0, 4'd0, 1'b0, 1'b0, "os_done_hold"); tick();
    end
    start = 1'b1;
    expect_out(0, 4'd3, 1'b0, 1'b1, "os_restart"); tick();
    start = 1'b0;
    expect_out(0, 4'd2, 1'b0, 1'b1, "os_rerun"); tick();

    // 4: RELOAD up on MAX_VAL=9
    mode = 2'b11; up_dn = 1'b1; load = 1'b1; load_val = 4'd7;
    expect_out(1, 4'd7, 1'b0, 1'b0, "rl_load"); tick();
    load = 1'b0;
    for (int r = 0; r < 2; r++) begin
      expect_out(1, 4'd8, 1'b0, 1'b0, "rl_8"); tick();
      expect_out(1, 4'd9, 1'b0, 1'b0, "rl_9"); tick();
      expect_out(1, 4'd7, 1'b1, 1'b0, "rl_tc"); tick();
    end

    // 5: PRESC=3 WRAP up, with an en gap mid-period
    mode = 2'b00; up_dn = 1'b1; load = 1'b1; load_val = 4'd0;
    expect_out(2, 4'd0, 1'b0, 1'b0, "ps_load"); tick();
    load = 1'b0;
    expect_out(2, 4'd0, 1'b0, 1'b0, "ps_p1"); tick();
    expect_out(2, 4'd0, 1'b0, 1'b0, "ps_p2"); tick();
    expect_out(2, 4'd1, 1'b0, 1'b0, "ps_s1"); tick();
    expect_out(2, 4'd1, 1'b0, 1'b0, "ps_p1b"); tick();
    expect_out(2, 4'd1, 1'b0, 1'b0, "ps_p2b"); tick();
    expect_out(2, 4'd2, 1'b0, 1'b0, "ps_s2"); tick();
    expect_out(2, 4'd2, 1'b0, 1'b0, "ps_p1c"); tick();
    en = 1'b0;
    expect_out(2, 4'd2, 1'b0, 1'b0, "ps_gap1"); tick();
    expect_out(2, 4'd2, 1'b0, 1'b0, "ps_gap2"); tick();
    en = 1'b1;
    expect_out(2, 4'd2, 1'b0, 1'b0, "ps_p2c"); tick();
    expect_out(2, 4'd3, 1'b0, 1'b0, "ps_s3"); tick();

    // 6: clamp with ignored start, then async reset mid-run
    mode = 2'b10; up_dn = 1'b0; load = 1'b1; start = 1'b1; load_val = 4'd12;
    expect_out(1, 4'd9, 1'b0, 1'b0, "clamp_load"); tick();
    load = 1'b0;
    expect_out(1, 4'd9, 1'b0, 1'b1, "clamp_start"); tick();
    start = 1'b0;
    expect_out(1, 4'd8, 1'b0, 1'b1, "clamp_run"); tick();
    #2 rst_n = 1'b0;
    #1;
    expect_out(1, 4'd0, 1'b0, 1'b0, "async_rst_b");
    expect_out(0, 4'd0, 1'b0, 1'b0, "async_rst_a");
    drain();
    #5 rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised synchronous successor to the 4-bit ripple down counter built from JK flip-flops. It provides width and modulus generics and run-time up/down direction. It also adds four terminal-count modes (wrap, saturate, one-shot, auto-reload), a synchronous load, a prescaler and a terminal-count pulse. Used as the general counter/timer primitive for timing and sequencing logic in the design.

Parameters:
WIDTH, 4, counter width in bits
MAX_VAL, 2**WIDTH-1, largest count value (modulus = MAX_VAL+1); must be ≥1 and ≤2**WIDTH-1
PRESC, 1, number of enabled cycles per count step; must be ≥1

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
en  in  1  count enable; freezes prescaler and count when low
up_dn  in  1  1 = count up, 0 = count down
mode  in  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 RELOAD
load  in  1  synchronous load of load_val into count and reload register
load_val  in  WIDTH  load value; clamped to MAX_VAL if larger
start  in  1  one-shot arm; restarts from the reload register
count  out  WIDTH  current count, registered
count_n  out  WIDTH  bitwise complement of count
tc  out  1  terminal-count pulse, one cycle, registered
busy  out  1  high while the one-shot is in the RUN state

Behaviour:
- Reset (rst_n low, asynchronous): count=0, count_n=all ones, tc=0, busy=0, reload register=0, prescaler=0, FSM=IDLE. Applies immediately, including mid-run.
- Step: occurs on a clk edge with en=1 and prescaler==PRESC-1. The prescaler then wraps to 0; otherwise it increments while en=1.
- Terminal value: MAX_VAL when up_dn=1, 0 when up_dn=0. It is evaluated against the up_dn sampled at that edge.
- Non-terminal step: count ±1.
- Terminal step (step taken while count == terminal value): tc=1 for exactly that next cycle, alongside the updated count. Per mode:
  - WRAP: count → 0 (up) or MAX_VAL (down).
  - SAT: count holds. tc pulses on every terminal step.
  - RELOAD: count → reload register.
  - ONESHOT: count holds, FSM RUN → DONE, busy → 0.
- ONESHOT FSM, states IDLE/RUN/DONE:
  - Steps are ignored in IDLE and DONE; prescaler is held at 0 there.
  - start in IDLE or DONE → RUN, count=reload register, prescaler=0, busy=1.
  - start in RUN restarts in the same way.
  - Leaving ONESHOT mode forces FSM to IDLE next edge, busy=0.
- Priority within one edge: load > start > step.
  - load: count and reload register ← min(load_val, MAX_VAL); prescaler=0; tc=0; FSM state unchanged, so RUN continues from the new value.
  - load and start together: start is ignored.
- count_n is always ~count, with no extra latency.
- Values above MAX_VAL are unreachable.
- Latency: count updates one clk after the qualifying edge inputs. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package cnt_pkg holds:
  - mode constants MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RELOAD;
  - a one-shot state enum (ST_IDLE, ST_RUN, ST_DONE).
- One sub-module, cnt_prescaler: PRESC-deep modulo counter with en and sync clear. Its output is a step strobe.
- Counter datapath, mode handling and FSM stay in the top module.

Test Plan:
1. WIDTH=4, WRAP, up_dn=0, en=1 after reset → count 0,15(tc=1),14,13,…,1,0,15(tc=1); count_n=~count every cycle.
2. SAT, up_dn=1, load 13 then steps → count 14, 15, 15, 15; tc=1 on each of the two steps taken at 15; stepping down afterwards → 14 with tc=0.
3. ONESHOT, up_dn=0, load 3, start → busy=1, count 3,2,1,0, next step tc=1, busy=0, count held at 0 for 5 further steps; start → count 3, busy=1.
4. RELOAD, MAX_VAL=9, up_dn=1, load 7 → count 8, 9, 7(tc=1), 8, 9, 7(tc=1).
5. PRESC=3, WRAP, up → count changes every 3rd en cycle; en low 2 cycles in mid-period → step delayed by exactly 2 cycles.
6. MAX_VAL=9: load_val=12 with start in the same cycle → count=9, start ignored; then in RUN, rst_n low mid-cycle → count=0, busy=0, tc=0 immediately, without waiting for a clk edge.
